// File: rtl/dmi_jtag_tap_multi.sv
// -----------------------------------------------------------------------------
// dmi_jtag_tap_multi
// IEEE 1149.1 TAP for the RISC-V debug transport module. It holds the 16-state
// TAP FSM, the instruction register and the BYPASS, IDCODE and DTMCS data
// registers. DR scans are routed to the DMI chain or to one of NumUserChan
// external user chains.
//
// Ports
//   tck_i, trst_ni          JTAG clock and asynchronous active-low reset
//   tms_i, td_i, td_o       TMS, TDI, TDO (TDO launched on the falling TCK edge)
//   tdo_oe_o                TDO output enable (Shift-IR or Shift-DR)
//   testmode_i              DFT: clock the TDO flops on non-inverted TCK
//   test_logic_reset_o,
//   capture_dr_o, shift_dr_o,
//   update_dr_o             TAP state decodes
//   dmi_access_o,
//   dtmcs_select_o,
//   user_select_o           IR decodes (user_select_o is one-hot)
//   dmi_reset_o,
//   dmi_hard_reset_o        one-TCK pulses issued after Update-DR of DTMCS
//   dmi_error_i             DMI status, captured into dtmcs.dmistat
//   chain_tdi_o             TDI forwarded to the external chains
//   dmi_tdo_i, user_tdo_i   serial outputs of the external chains
// -----------------------------------------------------------------------------
module dmi_jtag_tap_multi #(
  parameter int unsigned IrLength    = 5,
  parameter logic [31:0] IdcodeValue = 32'h00000001,
  parameter int unsigned NumUserChan = 2,
  parameter int unsigned UserIrBase  = 32'h12,
  parameter int unsigned DmiAbits    = 7,
  parameter int unsigned DmiIdle     = 1
) (
  input  logic                                        tck_i,
  input  logic                                        trst_ni,
  input  logic                                        tms_i,
  input  logic                                        td_i,
  output logic                                        td_o,
  output logic                                        tdo_oe_o,
  input  logic                                        testmode_i,
  output logic                                        test_logic_reset_o,
  output logic                                        capture_dr_o,
  output logic                                        shift_dr_o,
  output logic                                        update_dr_o,
  output logic                                        dmi_access_o,
  output logic [((NumUserChan > 0) ? NumUserChan : 1)-1:0] user_select_o,
  output logic                                        dtmcs_select_o,
  output logic                                        dmi_reset_o,
  output logic                                        dmi_hard_reset_o,
  input  logic [1:0]                                  dmi_error_i,
  output logic                                        chain_tdi_o,
  input  logic                                        dmi_tdo_i,
  input  logic [((NumUserChan > 0) ? NumUserChan : 1)-1:0] user_tdo_i
);

  localparam int unsigned UserW = (NumUserChan > 0) ? NumUserChan : 1;

  localparam logic [3:0] TestLogicReset = 4'd0;
  localparam logic [3:0] RunTestIdle    = 4'd1;
  localparam logic [3:0] SelectDrScan   = 4'd2;
  localparam logic [3:0] CaptureDr      = 4'd3;
  localparam logic [3:0] ShiftDr        = 4'd4;
  localparam logic [3:0] Exit1Dr        = 4'd5;
  localparam logic [3:0] PauseDr        = 4'd6;
  localparam logic [3:0] Exit2Dr        = 4'd7;
  localparam logic [3:0] UpdateDr       = 4'd8;
  localparam logic [3:0] SelectIrScan   = 4'd9;
  localparam logic [3:0] CaptureIr      = 4'd10;
  localparam logic [3:0] ShiftIr        = 4'd11;
  localparam logic [3:0] Exit1Ir        = 4'd12;
  localparam logic [3:0] PauseIr        = 4'd13;
  localparam logic [3:0] Exit2Ir        = 4'd14;
  localparam logic [3:0] UpdateIr       = 4'd15;

  localparam logic [IrLength-1:0] IrIdcode  = IrLength'(32'h01);
  localparam logic [IrLength-1:0] IrDtmcs   = IrLength'(32'h10);
  localparam logic [IrLength-1:0] IrDmi     = IrLength'(32'h11);
  localparam logic [IrLength-1:0] IrCapture = IrLength'(32'h05);
  localparam logic [2:0]          IdleField  = 3'(DmiIdle);
  localparam logic [5:0]          AbitsField = 6'(DmiAbits);

  logic [3:0]          r_state;
  logic [3:0]          w_state_next;
  logic [IrLength-1:0] r_ir;
  logic [IrLength-1:0] r_ir_shift;
  logic [31:0]         r_idcode;
  logic [31:0]         r_dtmcs;
  logic                r_bypass;
  logic                r_dmi_reset;
  logic                r_dmi_hard_reset;
  logic                r_tdo;
  logic                r_tdo_oe;
  logic                w_idcode_sel;
  logic                w_dtmcs_sel;
  logic                w_dmi_sel;
  logic [UserW-1:0]    w_user_sel;
  logic                w_user_any;
  logic                w_tdo_mux;
  logic                w_tdo_clk;
  logic [31:0]         w_dtmcs_cap;

  // TAP next-state logic, IEEE 1149.1 state graph
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      TestLogicReset: w_state_next = tms_i ? TestLogicReset : RunTestIdle;
      RunTestIdle:    w_state_next = tms_i ? SelectDrScan   : RunTestIdle;
      SelectDrScan:   w_state_next = tms_i ? SelectIrScan   : CaptureDr;
      CaptureDr:      w_state_next = tms_i ? Exit1Dr        : ShiftDr;
      ShiftDr:        w_state_next = tms_i ? Exit1Dr        : ShiftDr;
      Exit1Dr:        w_state_next = tms_i ? UpdateDr       : PauseDr;
      PauseDr:        w_state_next = tms_i ? Exit2Dr        : PauseDr;
      Exit2Dr:        w_state_next = tms_i ? UpdateDr       : ShiftDr;
      UpdateDr:       w_state_next = tms_i ? SelectDrScan   : RunTestIdle;
      SelectIrScan:   w_state_next = tms_i ? TestLogicReset : CaptureIr;
      CaptureIr:      w_state_next = tms_i ? Exit1Ir        : ShiftIr;
      ShiftIr:        w_state_next = tms_i ? Exit1Ir        : ShiftIr;
      Exit1Ir:        w_state_next = tms_i ? UpdateIr       : PauseIr;
      PauseIr:        w_state_next = tms_i ? Exit2Ir        : PauseIr;
      Exit2Ir:        w_state_next = tms_i ? UpdateIr       : ShiftIr;
      UpdateIr:       w_state_next = tms_i ? SelectDrScan   : RunTestIdle;
      default:        w_state_next = TestLogicReset;
    endcase
  end

  // TAP state register
  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      r_state <= TestLogicReset;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Instruction register and its shift stage
  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      r_ir       <= IrIdcode;
      r_ir_shift <= '0;
    end else begin
      case (r_state)
        TestLogicReset: begin
          r_ir       <= IrIdcode;
          r_ir_shift <= '0;
        end
        CaptureIr: r_ir_shift <= IrCapture;
        ShiftIr:   r_ir_shift <= {td_i, r_ir_shift[IrLength-1:1]};
        UpdateIr:  r_ir       <= r_ir_shift;
        default:   r_ir_shift <= r_ir_shift;
      endcase
    end
  end

  // IR decode; codes 0 and all-ones fall through to BYPASS with every other
  // unrecognised value
  always_comb begin
    w_idcode_sel = (r_ir == IrIdcode);
    w_dtmcs_sel  = (r_ir == IrDtmcs);
    w_dmi_sel    = (r_ir == IrDmi);
    w_user_sel   = '0;
    for (int i = 0; i < int'(NumUserChan); i++) begin
      w_user_sel[i] = (r_ir == IrLength'(UserIrBase + 32'(i)));
    end
    w_user_any = |w_user_sel;
  end

  assign w_dtmcs_cap = {14'b0, 1'b0, 1'b0, 1'b0, IdleField, dmi_error_i, AbitsField, 4'd1};

  // Internal data registers: capture, shift LSB-first, clear in Test-Logic-Reset
  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      r_idcode <= IdcodeValue;
      r_bypass <= 1'b0;
      r_dtmcs  <= 32'h0;
    end else begin
      case (r_state)
        TestLogicReset: begin
          r_idcode <= IdcodeValue;
          r_bypass <= 1'b0;
        end
        CaptureDr: begin
          if (w_idcode_sel) r_idcode <= IdcodeValue;
          if (w_dtmcs_sel)  r_dtmcs  <= w_dtmcs_cap;
          r_bypass <= 1'b0;
        end
        ShiftDr: begin
          if (w_idcode_sel) r_idcode <= {td_i, r_idcode[31:1]};
          if (w_dtmcs_sel)  r_dtmcs  <= {td_i, r_dtmcs[31:1]};
          r_bypass <= td_i;
        end
        default: r_bypass <= r_bypass;
      endcase
    end
  end

  // dmireset / dmihardreset pulses, one TCK long, only from a DTMCS update
  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      r_dmi_reset      <= 1'b0;
      r_dmi_hard_reset <= 1'b0;
    end else if ((r_state == UpdateDr) && w_dtmcs_sel) begin
      r_dmi_reset      <= r_dtmcs[16];
      r_dmi_hard_reset <= r_dtmcs[17];
    end else begin
      r_dmi_reset      <= 1'b0;
      r_dmi_hard_reset <= 1'b0;
    end
  end

  // TDO source selection
  always_comb begin
    if (r_state == ShiftIr) begin
      w_tdo_mux = r_ir_shift[0];
    end else if (w_idcode_sel) begin
      w_tdo_mux = r_idcode[0];
    end else if (w_dtmcs_sel) begin
      w_tdo_mux = r_dtmcs[0];
    end else if (w_dmi_sel) begin
      w_tdo_mux = dmi_tdo_i;
    end else if (w_user_any) begin
      w_tdo_mux = |(user_tdo_i & w_user_sel);
    end else begin
      w_tdo_mux = r_bypass;
    end
  end

  // In test mode the TDO flops run on the plain TCK so scan sees one clock edge
  assign w_tdo_clk = testmode_i ? tck_i : ~tck_i;

  // TDO launch flops, half a cycle after the state/shift update
  always_ff @(posedge w_tdo_clk or negedge trst_ni) begin
    if (!trst_ni) begin
      r_tdo    <= 1'b0;
      r_tdo_oe <= 1'b0;
    end else begin
      r_tdo    <= w_tdo_mux;
      r_tdo_oe <= (r_state == ShiftIr) || (r_state == ShiftDr);
    end
  end

  assign td_o               = r_tdo;
  assign tdo_oe_o           = r_tdo_oe;
  assign test_logic_reset_o = (r_state == TestLogicReset);
  assign capture_dr_o       = (r_state == CaptureDr);
  assign shift_dr_o         = (r_state == ShiftDr);
  assign update_dr_o        = (r_state == UpdateDr);
  assign dmi_access_o       = w_dmi_sel;
  assign dtmcs_select_o     = w_dtmcs_sel;
  assign user_select_o      = w_user_sel;
  assign dmi_reset_o        = r_dmi_reset;
  assign dmi_hard_reset_o   = r_dmi_hard_reset;
  assign chain_tdi_o        = td_i;

endmodule

// File: tb/tb_dmi_jtag_tap_multi.sv
// -----------------------------------------------------------------------------
// tb_dmi_jtag_tap_multi
// Drives JTAG IR/DR scans with random instructions and data and compares the
// scanned-out bits, IR decodes and DTMCS reset pulses against a reference
// model derived from the TAP rules (register contents, not FSM encodings).
// -----------------------------------------------------------------------------
module tb_dmi_jtag_tap_multi;

  localparam int          IR_LEN   = 5;
  localparam int          NUM_USER = 2;
  localparam logic [31:0] IDCODE   = 32'h4BA1_0C93;
  localparam int          ABITS    = 7;
  localparam int          IDLE     = 1;

  logic       tck_i = 1'b0;
  logic       trst_ni = 1'b0;
  logic       tms_i = 1'b0;
  logic       td_i = 1'b0;
  logic       td_o;
  logic       tdo_oe_o;
  logic       testmode_i = 1'b0;
  logic       test_logic_reset_o;
  logic       capture_dr_o;
  logic       shift_dr_o;
  logic       update_dr_o;
  logic       dmi_access_o;
  logic [1:0] user_select_o;
  logic       dtmcs_select_o;
  logic       dmi_reset_o;
  logic       dmi_hard_reset_o;
  logic [1:0] dmi_error_i = 2'd0;
  logic       chain_tdi_o;
  logic       dmi_tdo_i = 1'b0;
  logic [1:0] user_tdo_i = 2'd0;

  int n_checks = 0;
  int n_fail   = 0;
  logic [IR_LEN-1:0] ir_m;   // model: instruction currently in effect

  dmi_jtag_tap_multi #(
    .IrLength(IR_LEN), .IdcodeValue(IDCODE), .NumUserChan(NUM_USER),
    .UserIrBase(32'h12), .DmiAbits(ABITS), .DmiIdle(IDLE)
  ) dut (
    .tck_i(tck_i), .trst_ni(trst_ni), .tms_i(tms_i), .td_i(td_i), .td_o(td_o),
    .tdo_oe_o(tdo_oe_o), .testmode_i(testmode_i),
    .test_logic_reset_o(test_logic_reset_o), .capture_dr_o(capture_dr_o),
    .shift_dr_o(shift_dr_o), .update_dr_o(update_dr_o),
    .dmi_access_o(dmi_access_o), .user_select_o(user_select_o),
    .dtmcs_select_o(dtmcs_select_o), .dmi_reset_o(dmi_reset_o),
    .dmi_hard_reset_o(dmi_hard_reset_o), .dmi_error_i(dmi_error_i),
    .chain_tdi_o(chain_tdi_o), .dmi_tdo_i(dmi_tdo_i), .user_tdo_i(user_tdo_i)
  );

  // JTAG clock
  always #5 tck_i = ~tck_i;

  // Run-time bound
  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One TCK cycle: drive TMS/TDI and fresh random chain outputs, then sample
  // after the falling edge has launched TDO
  task automatic tick(input logic tms, input logic tdi);
    tms_i      = tms;
    td_i       = tdi;
    dmi_tdo_i  = 1'($urandom);
    user_tdo_i = 2'($urandom);
    @(posedge tck_i);
    #6;
  endtask

  // Model: 0 bypass, 1 idcode, 2 dtmcs, 3 dmi, 4+k user channel k
  function automatic int kind_of(input logic [IR_LEN-1:0] c);
    if (c == 5'h01) return 1;
    if (c == 5'h10) return 2;
    if (c == 5'h11) return 3;
    if ((int'(c) >= 32'h12) && (int'(c) < 32'h12 + NUM_USER)) return 4 + int'(c) - 32'h12;
    return 0;
  endfunction

  task automatic ir_scan(input logic [IR_LEN-1:0] code);
    logic [IR_LEN-1:0] out;
    out = '0;
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    for (int i = 0; i < IR_LEN; i++) begin
      out[i] = td_o;
      if (i == 0) check_val("ir_oe", 32'(tdo_oe_o), 32'd1);
      tick(i == IR_LEN - 1, code[i]);
    end
    check_val("ir_capture_out", 32'(out), 32'h05);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    ir_m = code;
  endtask

  // 32-bit DR scan from Run-Test-Idle; returns shifted-out bits, the chain
  // bits the bench presented, and the two pulse samples after Update-DR
  task automatic dr_scan(input logic [31:0] din, output logic [31:0] dout,
                         output logic [31:0] chain, output logic p_rst, output logic p_hrst);
    int k;
    k     = kind_of(ir_m);
    dout  = '0;
    chain = '0;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    check_val("capture_dr", 32'(capture_dr_o), 32'd1);
    tick(1'b0, 1'b0);
    for (int i = 0; i < 32; i++) begin
      dout[i]  = td_o;
      chain[i] = (k == 3) ? dmi_tdo_i : (k >= 4) ? user_tdo_i[k-4] : 1'b0;
      if (i == 0) begin
        check_val("shift_dr", 32'(shift_dr_o), 32'd1);
        check_val("dr_oe", 32'(tdo_oe_o), 32'd1);
      end
      if (i == 5) check_val("chain_tdi", 32'(chain_tdi_o), 32'(td_i));
      tick(i == 31, din[i]);
    end
    check_val("dr_oe_off", 32'(tdo_oe_o), 32'd0);
    tick(1'b1, 1'b0);
    check_val("update_dr", 32'(update_dr_o), 32'd1);
    tick(1'b0, 1'b0);
    p_rst  = dmi_reset_o;
    p_hrst = dmi_hard_reset_o;
    tick(1'b0, 1'b0);
    check_val("pulse_clear", 32'({dmi_hard_reset_o, dmi_reset_o}), 32'd0);
  endtask

  // Full IR + DR transaction checked against the model
  task automatic transact(input logic [IR_LEN-1:0] code, input logic [31:0] din);
    logic [31:0] dout, chain, exp;
    logic        p_rst, p_hrst;
    int          k;
    logic [1:0]  err;
    err         = 2'($urandom);
    dmi_error_i = err;
    ir_scan(code);
    k = kind_of(code);
    check_val("sel_dmi", 32'(dmi_access_o), 32'(k == 3));
    check_val("sel_dtmcs", 32'(dtmcs_select_o), 32'(k == 2));
    check_val("sel_user", 32'(user_select_o), (k >= 4) ? (32'd1 << (k - 4)) : 32'd0);
    dr_scan(din, dout, chain, p_rst, p_hrst);
    case (k)
      0:       exp = {din[30:0], 1'b0};
      1:       exp = IDCODE;
      2:       exp = (IDLE << 12) | (int'(err) << 10) | (ABITS << 4) | 1;
      default: exp = chain;
    endcase
    check_val($sformatf("dr_out_ir%0h", code), dout, exp);
    check_val("dmi_reset", 32'(p_rst), (k == 2) ? 32'(din[16]) : 32'd0);
    check_val("dmi_hard_reset", 32'(p_hrst), (k == 2) ? 32'(din[17]) : 32'd0);
  endtask

  logic [IR_LEN-1:0] codes [9] = '{5'h00, 5'h01, 5'h10, 5'h11, 5'h12, 5'h13, 5'h1E, 5'h1F, 5'h0A};

  initial begin
    logic [31:0] dout, chain, din;
    logic        p_rst, p_hrst;
    ir_m = 5'h01;

    // Reset state
    #2;
    check_val("rst_tlr", 32'(test_logic_reset_o), 32'd1);
    check_val("rst_decodes", 32'({capture_dr_o, shift_dr_o, update_dr_o, dmi_access_o,
                                  dtmcs_select_o, user_select_o}), 32'd0);
    check_val("rst_tdo", 32'({td_o, tdo_oe_o}), 32'd0);
    check_val("rst_pulses", 32'({dmi_reset_o, dmi_hard_reset_o}), 32'd0);
    #20;
    trst_ni = 1'b1;
    tick(1'b0, 1'b0);
    check_val("rti", 32'(test_logic_reset_o), 32'd0);

    // IDCODE is selected straight out of reset
    dr_scan($urandom, dout, chain, p_rst, p_hrst);
    check_val("idcode_after_reset", dout, IDCODE);

    // Directed DTMCS pulses
    transact(5'h10, 32'h0003_0000);
    transact(5'h10, 32'h0001_0000);
    transact(5'h10, 32'h0002_0000);
    // Directed bypass on an unassigned code
    transact(5'h1E, 32'h0000_0005);

    // Random instruction/data mix
    for (int n = 0; n < 30; n++) begin
      din = $urandom;
      transact(codes[$urandom_range(0, 8)], din);
    end
    transact(5'($urandom), $urandom);

    // Five TMS=1 from Shift-DR reach Test-Logic-Reset, IR back to IDCODE
    ir_scan(5'h11);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
    check_val("tms5_tlr", 32'(test_logic_reset_o), 32'd1);
    tick(1'b1, 1'b0);
    check_val("tms5_ir", 32'({dmi_access_o, dtmcs_select_o, user_select_o}), 32'd0);
    tick(1'b0, 1'b0);
    ir_m = 5'h01;
    dr_scan($urandom, dout, chain, p_rst, p_hrst);
    check_val("tms5_idcode", dout, IDCODE);

    // trst mid Shift-DR of DTMCS: no pulse afterwards
    ir_scan(5'h10);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    din = 32'h0003_0000;
    for (int i = 0; i < 32; i++) tick(1'b0, din[i]);
    check_val("abort_dr_pre", 32'(shift_dr_o), 32'd1);
    trst_ni = 1'b0;
    #1;
    check_val("abort_dr_tlr", 32'(test_logic_reset_o), 32'd1);
    check_val("abort_dr_tdo", 32'({td_o, tdo_oe_o, dtmcs_select_o}), 32'd0);
    #2;
    trst_ni = 1'b1;
    tick(1'b1, 1'b0);
    check_val("abort_dr_pulse0", 32'({dmi_reset_o, dmi_hard_reset_o}), 32'd0);
    tick(1'b0, 1'b0);
    check_val("abort_dr_pulse1", 32'({dmi_reset_o, dmi_hard_reset_o}), 32'd0);

    // trst mid Shift-IR: immediate return to reset, IR = IDCODE
    ir_scan(5'h10);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    check_val("abort_ir_pre", 32'({td_o, tdo_oe_o}), 32'd3);
    trst_ni = 1'b0;
    #1;
    check_val("abort_ir_tlr", 32'(test_logic_reset_o), 32'd1);
    check_val("abort_ir_tdo", 32'({td_o, tdo_oe_o}), 32'd0);
    check_val("abort_ir_sel", 32'(dtmcs_select_o), 32'd0);
    #2;
    trst_ni = 1'b1;
    tick(1'b0, 1'b0);
    ir_m = 5'h01;
    dr_scan($urandom, dout, chain, p_rst, p_hrst);
    check_val("abort_ir_idcode", dout, IDCODE);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
